// File: rtl/brew_sequencer.sv
// Brew controller: qualifies water/capsule/cup sensors, then sequences heater and pump for a small or large dose.
// All outputs are registered Moore decodes of the next state; reset drops heater and pump asynchronously.
module brew_sequencer #(
   parameter int unsigned SENSOR_TIMEOUT = 16,
   parameter int unsigned HEAT_TIMEOUT   = 32,
   parameter int unsigned PUMP_SMALL     = 4,
   parameter int unsigned PUMP_LARGE     = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       BTN_SMALL,
   input  logic       BTN_LARGE,
   input  logic       SN,
   input  logic       SP,
   input  logic       SR,
   input  logic       TEMP_OK,
   input  logic       ACK,
   output logic       HEATER,
   output logic       PUMP,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAULT,
   output logic [2:0] ERR_CODE,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_CHECK = 3'b001,
      S_HEAT  = 3'b010,
      S_BREW  = 3'b011,
      S_DONE  = 3'b100,
      S_FAULT = 3'b101
   } state_t;

   localparam logic [2:0] E_NONE   = 3'b000;
   localparam logic [2:0] E_WATER  = 3'b001;
   localparam logic [2:0] E_CAPS   = 3'b010;
   localparam logic [2:0] E_CUP    = 3'b011;
   localparam logic [2:0] E_SENSTO = 3'b100;
   localparam logic [2:0] E_HEATTO = 3'b101;

   localparam logic [7:0] SENS_LAST  = 8'(SENSOR_TIMEOUT - 1);
   localparam logic [7:0] HEAT_LAST  = 8'(HEAT_TIMEOUT - 1);
   localparam logic [7:0] SMALL_LAST = 8'(PUMP_SMALL - 1);
   localparam logic [7:0] LARGE_LAST = 8'(PUMP_LARGE - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q;
   logic       large_q, large_d;
   logic [2:0] err_q, err_d;
   logic       heater_q, pump_q, busy_q, done_q, fault_q;
   logic [7:0] pump_last;

   assign pump_last = large_q ? LARGE_LAST : SMALL_LAST;

   always_comb begin
      state_d = state_q;
      large_d = large_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            err_d = E_NONE;
            if (BTN_SMALL || BTN_LARGE) begin
               large_d = BTN_LARGE;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (SN || SP || SR) begin
               if (cnt_q == SENS_LAST) begin
                  state_d = S_FAULT;
                  err_d   = E_SENSTO;
               end else if (SN) begin
                  err_d = E_WATER;
               end else if (SP) begin
                  err_d = E_CAPS;
               end else begin
                  err_d = E_CUP;
               end
            end else begin
               state_d = S_HEAT;
               err_d   = E_NONE;
            end
         end
         S_HEAT: begin
            if (TEMP_OK) begin
               state_d = S_BREW;
            end else if (cnt_q == HEAT_LAST) begin
               state_d = S_FAULT;
               err_d   = E_HEATTO;
            end
         end
         S_BREW: begin
            // Capsule is already consumed here, so only water and cup can abort.
            if (SN) begin
               state_d = S_FAULT;
               err_d   = E_WATER;
            end else if (SR) begin
               state_d = S_FAULT;
               err_d   = E_CUP;
            end else if (cnt_q == pump_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = E_NONE;
         end
         S_FAULT: begin
            if (ACK) begin
               state_d = S_IDLE;
               err_d   = E_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            err_d   = E_NONE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         large_q  <= 1'b0;
         err_q    <= E_NONE;
         heater_q <= 1'b0;
         pump_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
         large_q  <= large_d;
         err_q    <= err_d;
         heater_q <= (state_d == S_HEAT) || (state_d == S_BREW);
         pump_q   <= (state_d == S_BREW);
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
         fault_q  <= (state_d == S_FAULT);
      end
   end

   assign HEATER   = heater_q;
   assign PUMP     = pump_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign FAULT    = fault_q;
   assign ERR_CODE = err_q;
   assign STATE    = state_q;

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
Top-level brew controller for the coffee machine. It accepts a drink request, qualifies the machine against the water (SN), capsule (SP) and cup (SR) sensors, then sequences the heater and pump for a small or large dose. Faults and completion are reported to the panel/display logic. It sits between the front-panel buttons and the heater/pump drivers and uses the same 3-bit error encoding as the sensor-analysis FSM.

Parameters:
SENSOR_TIMEOUT, 16, cycles a sensor fault may persist in CHECK before the sensor-failure fault (1..255)
HEAT_TIMEOUT, 32, max cycles in HEAT waiting for TEMP_OK (1..255)
PUMP_SMALL, 4, pump-on cycles for a small dose (1..255)
PUMP_LARGE, 8, pump-on cycles for a large dose (1..255)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
BTN_SMALL  input  1  small-dose request (level, synchronous)
BTN_LARGE  input  1  large-dose request (level, synchronous)
SN  input  1  1 = no water
SP  input  1  1 = no capsule
SR  input  1  1 = no cup
TEMP_OK  input  1  1 = water at brew temperature
ACK  input  1  operator fault acknowledge
HEATER  output  1  heater enable
PUMP  output  1  pump enable
BUSY  output  1  1 in any state other than IDLE
DONE  output  1  one-cycle pulse on brew completion
FAULT  output  1  1 while in FAULT state
ERR_CODE  output  3  000 none, 001 water, 010 capsule, 011 cup, 100 sensor timeout, 101 heat timeout
STATE  output  3  current state, for debug/display

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low (RST_N). All flops clear immediately on RST_N=0.
- Reset values: STATE=IDLE, all outputs 0, ERR_CODE=000, counter=0, size latch=small.
- Reset mid-brew drops HEATER and PUMP asynchronously.
- States (STATE encoding): IDLE=000, CHECK=001, HEAT=010, BREW=011, DONE=100, FAULT=101.
- Moore outputs: each is decoded from the state register, so it changes on the edge the state changes.
- 8-bit cycle counter. It clears on every state change and increments each cycle otherwise.
- IDLE: if BTN_SMALL or BTN_LARGE is sampled high, latch the size and go to CHECK. If both are high, LARGE wins. Buttons are ignored in all other states.
- CHECK: priority SN > SP > SR.
  - No sensor active: go to HEAT next edge, ERR_CODE=000.
  - Sensor active: ERR_CODE shows that sensor's code (updated each cycle) while waiting. Once the counter reaches SENSOR_TIMEOUT-1 with any sensor still active, go to FAULT with ERR_CODE=100.
- HEAT: HEATER=1.
  - TEMP_OK sampled high: go to BREW.
  - Counter reaches HEAT_TIMEOUT-1 with TEMP_OK low: go to FAULT with ERR_CODE=101.
  - TEMP_OK and timeout on the same edge: TEMP_OK wins.
- BREW: HEATER=1, PUMP=1 for exactly N cycles (N = PUMP_LARGE if large was latched, else PUMP_SMALL). Go to DONE when the counter reaches N-1.
- Abort during BREW: SN or SR sampled high goes to FAULT with code 001 or 011; SN wins if both are high. The abort takes priority over completion on the same edge. SP is ignored during BREW because the capsule is consumed.
- DONE: DONE=1 for exactly one cycle, then IDLE. ERR_CODE=000.
- FAULT:
  - FAULT=1, HEATER=0, PUMP=0, ERR_CODE held.
  - ACK sampled high: go to IDLE and clear ERR_CODE.
  - A held button after ACK starts a new cycle only from IDLE, on the following edge.
- Latency, all sensors clear and TEMP_OK high: request edge → CHECK → HEAT → BREW. PUMP rises 3 edges after the request edge and stays high N cycles, then DONE pulses.
- Unused encodings 110/111 recover to IDLE on the next edge.

Test Plan:
1. Reset, then BTN_SMALL for 1 cycle with SN=SP=SR=0 and TEMP_OK=1 → STATE 001,010,011. PUMP high exactly 4 cycles, then DONE pulses 1 cycle, back to IDLE, ERR_CODE=000.
2. BTN_SMALL and BTN_LARGE together → PUMP high 8 cycles. A button press during BREW has no effect.
3. SP=1 at request and held → ERR_CODE=010 in CHECK, FAULT with 100 after 16 cycles. ACK → IDLE, ERR_CODE=000.
4. SR=1 at request, cleared after 5 cycles → proceeds to HEAT with no fault. TEMP_OK held low for 32 cycles → FAULT, ERR_CODE=101, HEATER=0.
5. SR rises on the 2nd BREW cycle → next edge FAULT, PUMP=0, ERR_CODE=011. With SN and SR both rising → ERR_CODE=001.
6. RST_N low mid-BREW, asynchronous to CLK → HEATER, PUMP and BUSY go 0 immediately and STATE=000 before the next CLK edge.
